alu_muldiv: RTL and testbench

- Parametrised iterative multiply/divide unit; next-generation companion to the single-cycle ALU for 6502/65Org16/wider cores.
- Radix-2 shift-add multiply and restoring divide, signed or unsigned, one step per RDY-qualified clock.
- Sits beside the ALU in the core datapath. Operands come from the same AI/BI sources. The low result feeds back like the ALU OUT.
- Flags follow ALU conventions (Z, N, V), and it honours the core-wide RDY stall.

---
 rtl/alu_defs.sv | 26 ++
 rtl/alu_negate.sv | 12 +
 rtl/alu_muldiv.sv | 194 +++++++++++++++++++
 tb/tb_alu_muldiv.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/alu_defs.sv
// rtl/alu_defs.sv - shared op and state encodings for the iterative multiply/divide unit
package alu_defs;

  typedef enum logic [1:0] {
    OP_MULU = 2'b00,
    OP_MULS = 2'b01,
    OP_DIVU = 2'b10,
    OP_DIVS = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } md_state_e;

  function automatic logic op_is_div(input logic [1:0] o);
    return o[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] o);
    return o[0];
  endfunction

endpackage

// File: rtl/alu_negate.sv
// rtl/alu_negate.sv - conditional two's-complement negation of a W-bit value
module alu_negate #(
  parameter int W = 16
) (
  input  logic [W-1:0] value_i,
  input  logic         neg_i,
  output logic [W-1:0] result_o
);

  assign result_o = neg_i ? (~value_i + W'(1)) : value_i;

endmodule

// File: rtl/alu_muldiv.sv
// rtl/alu_muldiv.sv - radix-2 shift-add multiply / restoring divide, signed or unsigned, RDY-stallable
module alu_muldiv #(
  parameter int dw = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          RDY,
  input  logic          start,
  input  logic [1:0]    op,
  input  logic [dw-1:0] AI,
  input  logic [dw-1:0] BI,
  output logic [dw-1:0] OUT_LO,
  output logic [dw-1:0] OUT_HI,
  output logic          busy,
  output logic          done,
  output logic          Z,
  output logic          N,
  output logic          V
);
  import alu_defs::*;

  localparam int CW = $clog2(dw);

  md_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      op_q, op_d;
  logic            sa_q, sa_d, sb_q, sb_d;
  logic [dw:0]     acc_q, acc_d;
  logic [dw-1:0]   lo_q, lo_d;
  logic [dw-1:0]   b_q, b_d;
  logic [dw-1:0]   out_lo_q, out_lo_d, out_hi_q, out_hi_d;
  logic            z_q, z_d, n_q, n_d, v_q, v_d;

  logic            a_neg, b_neg;
  logic [dw-1:0]   a_mag, b_mag;

  assign a_neg = op_is_signed(op) & AI[dw-1];
  assign b_neg = op_is_signed(op) & BI[dw-1];

  // Magnitude of the most-negative operand lands as unsigned 2^(dw-1).
  alu_negate #(.W(dw)) u_neg_a (.value_i(AI), .neg_i(a_neg), .result_o(a_mag));
  alu_negate #(.W(dw)) u_neg_b (.value_i(BI), .neg_i(b_neg), .result_o(b_mag));

  logic [dw-1:0]   addend;
  logic [dw:0]     mul_sum;
  logic [dw:0]     div_sh;
  logic [dw+1:0]   div_diff;
  logic            div_ge;

  assign addend   = lo_q[0] ? b_q : '0;
  assign mul_sum  = acc_q + {1'b0, addend};
  assign div_sh   = {acc_q[dw-1:0], lo_q[dw-1]};
  assign div_diff = {1'b0, div_sh} - {2'b00, b_q};
  assign div_ge   = ~div_diff[dw+1];

  logic [2*dw-1:0] prod_fix;
  logic [dw-1:0]   quo_fix, rem_fix;

  alu_negate #(.W(2*dw)) u_neg_prod (
    .value_i ({acc_q[dw-1:0], lo_q}),
    .neg_i   (sa_q ^ sb_q),
    .result_o(prod_fix)
  );
  alu_negate #(.W(dw)) u_neg_quo (.value_i(lo_q), .neg_i(sa_q ^ sb_q), .result_o(quo_fix));
  // Remainder follows the dividend's sign so division truncates toward zero.
  alu_negate #(.W(dw)) u_neg_rem (.value_i(acc_q[dw-1:0]), .neg_i(sa_q), .result_o(rem_fix));

  logic [dw-1:0]   fix_lo, fix_hi;
  logic            fix_z, fix_n, fix_v;

  always_comb begin
    fix_lo = prod_fix[dw-1:0];
    fix_hi = prod_fix[2*dw-1:dw];
    fix_z  = (prod_fix == '0);
    fix_n  = prod_fix[2*dw-1];
    fix_v  = op_is_signed(op_q) ? (fix_hi != {dw{fix_lo[dw-1]}}) : (fix_hi != '0);
    if (op_is_div(op_q)) begin
      fix_lo = quo_fix;
      fix_hi = rem_fix;
      fix_z  = (quo_fix == '0);
      fix_n  = quo_fix[dw-1];
      // A positive quotient of magnitude 2^(dw-1) only arises from most-negative / -1.
      fix_v  = op_is_signed(op_q) & ~(sa_q ^ sb_q) & lo_q[dw-1];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    acc_d    = acc_q;
    lo_d     = lo_q;
    b_d      = b_q;
    out_lo_d = out_lo_q;
    out_hi_d = out_hi_q;
    z_d      = z_q;
    n_d      = n_q;
    v_d      = v_q;
    if (RDY) begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          state_d = ST_IDLE;
          if (start) begin
            op_d  = op;
            sa_d  = a_neg;
            sb_d  = b_neg;
            acc_d = '0;
            cnt_d = CW'(dw - 1);
            if (op_is_div(op)) begin
              lo_d = a_mag;
              b_d  = b_mag;
            end else begin
              lo_d = b_mag;
              b_d  = a_mag;
            end
            if (op_is_div(op) && (BI == '0)) begin
              state_d  = ST_DONE;
              out_lo_d = '1;
              out_hi_d = AI;
              z_d      = 1'b0;
              n_d      = 1'b1;
              v_d      = 1'b1;
            end else begin
              state_d = ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (op_is_div(op_q)) begin
            acc_d = div_ge ? div_diff[dw:0] : div_sh;
            lo_d  = {lo_q[dw-2:0], div_ge};
          end else begin
            acc_d = {1'b0, mul_sum[dw:1]};
            lo_d  = {mul_sum[0], lo_q[dw-1:1]};
          end
          if (cnt_q == '0) state_d = ST_FIX;
          else             cnt_d   = cnt_q - CW'(1);
        end
        ST_FIX: begin
          out_lo_d = fix_lo;
          out_hi_d = fix_hi;
          z_d      = fix_z;
          n_d      = fix_n;
          v_d      = fix_v;
          state_d  = ST_DONE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      acc_q    <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      out_lo_q <= '0;
      out_hi_q <= '0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      v_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      acc_q    <= acc_d;
      lo_q     <= lo_d;
      b_q      <= b_d;
      out_lo_q <= out_lo_d;
      out_hi_q <= out_hi_d;
      z_q      <= z_d;
      n_q      <= n_d;
      v_q      <= v_d;
    end
  end

  assign busy   = (state_q == ST_RUN) || (state_q == ST_FIX);
  assign done   = (state_q == ST_DONE);
  assign OUT_LO = out_lo_q;
  assign OUT_HI = out_hi_q;
  assign Z      = z_q;
  assign N      = n_q;
  assign V      = v_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// tb/tb_alu_muldiv.sv - directed self-checking bench for alu_muldiv at dw=16
module tb_alu_muldiv;

  logic        clk = 1'b0;
  logic        reset;
  logic        RDY;
  logic        start;
  logic [1:0]  op;
  logic [15:0] AI, BI;
  logic [15:0] OUT_LO, OUT_HI;
  logic        busy, done, Z, N, V;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;
  int lat;
  logic busy_all;

  always #5 clk = ~clk;

  alu_muldiv #(.dw(16)) dut (
    .clk   (clk),
    .reset (reset),
    .RDY   (RDY),
    .start (start),
    .op    (op),
    .AI    (AI),
    .BI    (BI),
    .OUT_LO(OUT_LO),
    .OUT_HI(OUT_HI),
    .busy  (busy),
    .done  (done),
    .Z     (Z),
    .N     (N),
    .V     (V)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
    op = o;
    AI = a;
    BI = b;
    start = 1'b1;
    step();
    start = 1'b0;
    op = 2'($urandom);
    AI = 16'($urandom);
    BI = 16'($urandom);
  endtask

  // lat counts clock edges after the accepting edge until done is seen.
  task automatic wait_done(output int l, output logic b_all);
    l = 0;
    b_all = 1'b1;
    while (!done && l < 60) begin
      if (!busy) b_all = 1'b0;
      step();
      l++;
    end
    if (!done) l = -1;
  endtask

  task automatic check_res(input string tag, input logic [15:0] lo, input logic [15:0] hi,
                           input logic [2:0] znv);
    check({tag, "_lo"}, 32'(OUT_LO), 32'(lo));
    check({tag, "_hi"}, 32'(OUT_HI), 32'(hi));
    check({tag, "_znv"}, 32'({Z, N, V}), 32'(znv));
  endtask

  task automatic run(input string tag, input logic [1:0] o, input logic [15:0] a,
                     input logic [15:0] b, input int exp_lat, input logic [15:0] lo,
                     input logic [15:0] hi, input logic [2:0] znv);
    start_op(o, a, b);
    wait_done(lat, busy_all);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_busy_run"}, 32'(busy_all), 32'd1);
    check({tag, "_busy_done"}, 32'(busy), 32'd0);
    check_res(tag, lo, hi, znv);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    RDY = 1'b1;
    start = 1'b0;
    op = 2'b00;
    AI = '0;
    BI = '0;
    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check_res("rst", 16'h0000, 16'h0000, 3'b000);
    step();
    step();
    reset = 1'b0;
    step();

    run("mulu_ffff", 2'b00, 16'hFFFF, 16'hFFFF, 17, 16'h0001, 16'hFFFE, 3'b011);
    step();
    check("done_one_cycle", 32'(done), 32'd0);
    check_res("hold_idle", 16'h0001, 16'hFFFE, 3'b011);

    run("muls_neg2x3", 2'b01, 16'hFFFE, 16'h0003, 17, 16'hFFFA, 16'hFFFF, 3'b010);
    run("mulu_zero", 2'b00, 16'h0000, 16'h1234, 17, 16'h0000, 16'h0000, 3'b100);
    run("muls_minmin", 2'b01, 16'h8000, 16'h8000, 17, 16'h0000, 16'h4000, 3'b001);
    run("divs_m7d2", 2'b11, 16'hFFF9, 16'h0002, 17, 16'hFFFD, 16'hFFFF, 3'b010);
    run("divs_7dm2", 2'b11, 16'h0007, 16'hFFFE, 17, 16'hFFFD, 16'h0001, 3'b010);
    run("divu_1234", 2'b10, 16'h1234, 16'h0010, 17, 16'h0123, 16'h0004, 3'b000);
    run("divu_small", 2'b10, 16'h0003, 16'h0007, 17, 16'h0000, 16'h0003, 3'b100);
    run("divu_by0", 2'b10, 16'h1234, 16'h0000, 0, 16'hFFFF, 16'h1234, 3'b011);
    run("divs_ovf", 2'b11, 16'h8000, 16'hFFFF, 17, 16'h8000, 16'h0000, 3'b011);

    start_op(2'b00, 16'h1234, 16'h0010);
    lat = 0;
    while (!done && lat < 60) begin
      RDY = !(lat >= 4 && lat < 9);
      start = (lat == 10);
      op = 2'b10;
      AI = 16'h0005;
      BI = 16'h0000;
      step();
      lat++;
    end
    if (!done) lat = -1;
    RDY = 1'b1;
    check("stall_lat", 32'(lat), 32'd22);
    check_res("stall", 16'h2340, 16'h0001, 3'b001);

    run("b2b", 2'b00, 16'h0003, 16'h0005, 17, 16'h000F, 16'h0000, 3'b000);

    RDY = 1'b0;
    step();
    step();
    step();
    check("freeze_done", 32'(done), 32'd1);
    RDY = 1'b1;
    step();
    check("release_done", 32'(done), 32'd0);

    start_op(2'b10, 16'h1234, 16'h0010);
    for (int i = 0; i < 6; i++) step();
    reset = 1'b1;
    #2;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check_res("arst", 16'h0000, 16'h0000, 3'b000);
    step();
    reset = 1'b0;
    step();
    run("post_rst", 2'b10, 16'h00FF, 16'h0010, 17, 16'h000F, 16'h000F, 3'b000);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
